// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle block ROM read port and
// pairs each returned ROM word with the address that requested it.
module instruction_fetch #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [DATA_W-1:0] rom_douta,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {PRIME, RUN, HALT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] issued_pc, issued_pc_nx;
  logic              valid_r, valid_nx;
  logic              halted_nx;
  logic              halt_hit;

  // The ROM output is registered inside the ROM, so instr is a wire; only
  // the address it belongs to has to be tracked (issued_pc).
  assign instr       = rom_douta;
  assign instr_pc    = issued_pc;
  assign instr_valid = valid_r && (state == RUN) && !reset;

  // Next-state and ROM port decode; branch beats stall, stall beats advance.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    issued_pc_nx = issued_pc;
    valid_nx     = valid_r;
    halted_nx    = halted;
    rom_ena      = 1'b0;
    rom_addra    = pc;
    halt_hit     = 1'b0;

    case (state)
      PRIME: begin
        rom_ena      = 1'b1;
        rom_addra    = pc;
        issued_pc_nx = pc;
        pc_nx        = pc + 1'b1;
        valid_nx     = 1'b1;
        state_nx     = RUN;
      end

      RUN: begin
        halt_hit = valid_r && (rom_douta == HALT_WORD) && !stall && !branch_taken;
        if (branch_taken) begin
          // Redirect goes straight to the ROM so the target is on instr
          // next cycle with no bubble and no wrong-path word.
          rom_ena      = 1'b1;
          rom_addra    = branch_target;
          issued_pc_nx = branch_target;
          pc_nx        = branch_target + 1'b1;
          valid_nx     = 1'b1;
        end else if (stall) begin
          // ROM disabled: douta holds, so the presented word stays put.
          rom_ena = 1'b0;
        end else begin
          rom_ena      = 1'b1;
          rom_addra    = pc;
          issued_pc_nx = pc;
          pc_nx        = pc + 1'b1;
          if (halt_hit) begin
            // Halt word is consumed this cycle; nothing after it is shown.
            state_nx  = HALT;
            valid_nx  = 1'b0;
            halted_nx = 1'b1;
          end
        end
      end

      HALT: begin
        // Parked until reset.
        rom_ena = 1'b0;
      end

      default: state_nx = PRIME;
    endcase

    if (reset) begin
      rom_ena   = 1'b0;
      rom_addra = RESET_PC;
    end
  end

  // State register, PC bookkeeping and the accepted-instruction counter.
  always_ff @(posedge clka) begin
    if (reset) begin
      state       <= PRIME;
      pc          <= RESET_PC;
      issued_pc   <= RESET_PC;
      valid_r     <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      issued_pc <= issued_pc_nx;
      valid_r   <= valid_nx;
      halted    <= halted_nx;
      if (instr_valid && !stall)
        fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic,
// all checked against an instruction-level reference model.
module tb_instruction_fetch;

  localparam int          AW   = 10;
  localparam int          DW   = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clka = 1'b0;
  logic          reset, stall, branch_taken;
  logic [AW-1:0] branch_target;
  logic          rom_ena;
  logic [AW-1:0] rom_addra;
  logic [DW-1:0] rom_douta;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid, halted;
  logic [15:0]   fetch_count;

  always #5 clka = ~clka;

  instruction_fetch dut (
    .clka(clka), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_ena(rom_ena), .rom_addra(rom_addra), .rom_douta(rom_douta),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  // ROM: 1-cycle registered read, holds douta while disabled.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clka) if (rom_ena) rom_douta <= mem[rom_addra];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which instruction is on display, what is fetched next.
  logic          m_prime, m_valid, m_halted;
  logic [AW-1:0] m_cur, m_next;
  logic [15:0]   m_count;

  // Last observed DUT outputs, for directed constant checks.
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_pc, o_addr;
  logic          o_valid, o_ena, o_halted;
  logic [15:0]   o_count;

  task automatic model_update(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
    if (r) begin
      m_prime = 1; m_valid = 0; m_halted = 0; m_count = 0; m_next = '0; m_cur = '0;
    end else if (m_halted) begin
    end else if (m_prime) begin
      m_cur = m_next; m_next = m_cur + 1'b1; m_valid = 1; m_prime = 0;
    end else begin
      if (m_valid && !s) m_count = m_count + 16'd1;
      if (b) begin
        m_cur = t; m_next = t + 1'b1; m_valid = 1;
      end else if (s) begin
      end else if (m_valid && mem[m_cur] == HALT) begin
        m_halted = 1; m_valid = 0;
      end else begin
        m_cur = m_next; m_next = m_next + 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, compare combinational view, then advance.
  task automatic step(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
    logic          e_valid, e_ena;
    logic [AW-1:0] e_addr;
    @(negedge clka);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    e_valid = m_valid && !r;
    e_ena   = r ? 1'b0 : m_halted ? 1'b0 : m_prime ? 1'b1 : b ? 1'b1 : !s;
    e_addr  = r ? '0 : (m_prime || !b) ? m_next : t;
    chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
    if (e_valid) begin
      chk("instr", instr, mem[m_cur]);
      chk("instr_pc", {22'b0, instr_pc}, {22'b0, m_cur});
    end
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("count", {16'b0, fetch_count}, {16'b0, m_count});
    chk("rom_ena", {31'b0, rom_ena}, {31'b0, e_ena});
    if (e_ena || r) chk("rom_addra", {22'b0, rom_addra}, {22'b0, e_addr});
    o_instr = instr; o_pc = instr_pc; o_addr = rom_addra; o_valid = instr_valid;
    o_ena = rom_ena; o_halted = halted; o_count = fetch_count;
    @(posedge clka);
    model_update(r, s, b, t);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
    @(posedge clka);
    model_update(1, 0, 0, '0);

    // Startup: 3 reset cycles, PRIME, then 0, 1.
    repeat (3) step(1, 0, 0, '0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ena", {31'b0, o_ena}, 32'd0);
    step(0, 0, 0, '0);
    chk("prime_valid", {31'b0, o_valid}, 32'd0);
    chk("prime_addr", {22'b0, o_addr}, 32'd0);
    step(0, 0, 0, '0);
    chk("start_i0", o_instr, 32'h1000_0000);
    chk("start_pc0", {22'b0, o_pc}, 32'd0);
    step(0, 0, 0, '0);
    chk("start_i1", o_instr, 32'h1000_0001);
    chk("start_pc1", {22'b0, o_pc}, 32'd1);

    // Stall three cycles on pc 4.
    run(2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0);
      chk("stall_instr", o_instr, 32'h1000_0004);
      chk("stall_ena", {31'b0, o_ena}, 32'd0);
      chk("stall_cnt", {16'b0, o_count}, 32'd4);
    end
    step(0, 0, 0, '0); chk("resume_pc4", {22'b0, o_pc}, 32'd4);
    step(0, 0, 0, '0); chk("resume_pc5", {22'b0, o_pc}, 32'd5);
    step(0, 0, 0, '0); chk("resume_pc6", {22'b0, o_pc}, 32'd6);

    // Branch at pc 3 to 25, then the same with stall asserted too.
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, '0);
      run(4);
      step(0, k[0], 1, 10'd25);
      chk("br_from_pc3", {22'b0, o_pc}, 32'd3);
      step(0, 0, 0, '0);
      chk("br_instr", o_instr, 32'h1000_0019);
      chk("br_pc25", {22'b0, o_pc}, 32'd25);
      chk("br_cnt", {16'b0, o_count}, (k == 0) ? 32'd4 : 32'd3);
      step(0, 0, 0, '0);
      chk("br_pc26", {22'b0, o_pc}, 32'd26);
    end

    // Wrap-around through 1023.
    step(0, 0, 1, 10'd1022);
    step(0, 0, 0, '0); chk("wrap_pc1022", {22'b0, o_pc}, 32'd1022); chk("wrap_i3fe", o_instr, 32'h1000_03FE);
    step(0, 0, 0, '0); chk("wrap_pc1023", {22'b0, o_pc}, 32'd1023); chk("wrap_i3ff", o_instr, 32'h1000_03FF);
    step(0, 0, 0, '0); chk("wrap_pc0", {22'b0, o_pc}, 32'd0); chk("wrap_i0", o_instr, 32'h1000_0000);
    step(0, 0, 0, '0); chk("wrap_pc1", {22'b0, o_pc}, 32'd1);

    // Halt word at address 5.
    mem[5] = HALT;
    step(1, 0, 0, '0);
    run(6);
    step(0, 0, 0, '0);
    chk("halt_pc5", {22'b0, o_pc}, 32'd5);
    chk("halt_valid5", {31'b0, o_valid}, 32'd1);
    step(0, 0, 0, '0);
    chk("halted", {31'b0, o_halted}, 32'd1);
    chk("halt_valid", {31'b0, o_valid}, 32'd0);
    chk("halt_ena", {31'b0, o_ena}, 32'd0);
    chk("halt_cnt", {16'b0, o_count}, 32'd6);
    step(0, 0, 1, 10'd25);
    step(0, 1, 1, 10'd40);
    chk("halt_sticky", {31'b0, o_halted}, 32'd1);
    chk("halt_br_ena", {31'b0, o_ena}, 32'd0);
    mem[5] = 32'h1000_0005;
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("restart_pc0", {22'b0, o_pc}, 32'd0);
    chk("restart_valid", {31'b0, o_valid}, 32'd1);

    // Reset while pc 7 is on display.
    run(6);
    step(1, 0, 0, '0);
    chk("midrst_pc7", {22'b0, o_pc}, 32'd7);
    step(0, 0, 0, '0);
    chk("midrst_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_cnt", {16'b0, o_count}, 32'd0);
    chk("midrst_addr", {22'b0, o_addr}, 32'd0);
    step(0, 0, 0, '0);
    chk("midrst_pc0", {22'b0, o_pc}, 32'd0);

    // Randomized traffic, with a halt word planted in the program.
    mem[700] = HALT;
    for (int i = 0; i < 600; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      step(r, s, b, AW'($urandom_range(0, 1023)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the pipeline: the read side of the InstructionMemory block ROM (1024 x 32, 1-cycle registered read).
- Owns the program counter and drives the ROM enable/address.
- Aligns the returned ROM word with the PC that requested it and presents `instr`/`instr_pc`/`instr_valid` to decode.
- Handles stall, branch redirect, PC wrap-around and a halt instruction.

## Interface
Parameters:
- ADDR_W, 10, ROM word-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, first address fetched after reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching

Ports:
- clka  in  1  clock; same clock as the ROM
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- stall  in  1  decode cannot accept; hold current instruction
- branch_taken  in  1  redirect fetch to branch_target this cycle
- branch_target  in  ADDR_W  redirect word address
- rom_ena  out  1  ROM enable (connects to ena)
- rom_addra  out  ADDR_W  ROM address (connects to addra)
- rom_douta  in  DATA_W  ROM data (connects to douta); valid one cycle after the address is issued
- instr  out  DATA_W  current instruction (rom_douta passed through)
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr/instr_pc are meaningful
- halted  out  1  HALT_WORD has been delivered; fetching stopped
- fetch_count  out  16  number of instructions accepted by decode

## Operation
- **State machine:** PRIME, RUN, HALT. Reset forces PRIME.
- **PRIME:**
  - rom_ena=1, rom_addra=pc.
  - At the clock edge: issued_pc<=pc, pc<=pc+1, valid_r<=1, state<=RUN.
- **RUN, issue decision, highest priority first:**
  1. **branch_taken=1** (overrides stall):
     - rom_ena=1, rom_addra=branch_target (combinational mux).
     - At the edge: issued_pc<=branch_target, pc<=branch_target+1, valid_r<=1.
  2. **stall=1:**
     - rom_ena=0, so the ROM holds douta.
     - pc, issued_pc and valid_r are held.
  3. **Otherwise:**
     - rom_ena=1, rom_addra=pc.
     - At the edge: issued_pc<=pc, pc<=pc+1.
- **Outputs:** instr=rom_douta, instr_pc=issued_pc, instr_valid=valid_r (0 in PRIME and HALT).
- **Halt:**
  - Trigger: in RUN with instr_valid=1, instr==HALT_WORD, stall=0 and branch_taken=0.
  - The halt word is delivered normally in that cycle.
  - At the edge: state<=HALT, valid_r<=0, halted<=1.
  - branch_taken in the same cycle wins: no halt.
- **HALT:** rom_ena=0, instr_valid=0, all inputs except reset ignored. Only reset exits HALT.
- **fetch_count:** increments by 1 each cycle instr_valid=1 and stall=0. Wraps at 16 bits.
- **PC arithmetic:** ADDR_W bits, modulo 2^ADDR_W. 1023+1 wraps to 0; branch_target 1023 gives next pc 0.

## Timing
- **Reset values:**
  - pc=RESET_PC, issued_pc=RESET_PC, valid_r=0, state=PRIME, halted=0, fetch_count=0.
  - During reset: rom_ena=0, rom_addra=RESET_PC, instr_valid=0.
- **Reset mid-operation:** takes effect at the next edge from any state. An in-flight ROM read is discarded because valid_r=0.
- **Latency:**
  - Address issued in cycle N appears on instr in cycle N+1.
  - First valid instruction after reset deassertion: cycle 2 (cycle 1 is PRIME).
- **Branch:** branch_taken in cycle N puts the target instruction on instr in cycle N+1. No bubble; no wrong-path instruction is presented.
- **Stall:** instr, instr_pc and instr_valid are stable for every stalled cycle. Fetch resumes in the first cycle with stall=0; that cycle still shows the held instruction.
- **Stall + branch in the same cycle:** redirect occurs. The held instruction is dropped, and fetch_count does not increment.
- **Throughput:** one instruction per cycle when not stalled.

## Test plan
Bench ROM model: 1-cycle registered read, mem[i]=32'h1000_0000+i, except where a scenario sets a location to HALT_WORD.

- **Reset/startup:** hold reset 3 cycles, release.
  - Cycle 1: instr_valid=0, rom_addra=0.
  - Cycle 2: instr=32'h1000_0000, instr_pc=0.
  - Cycle 3: instr=32'h1000_0001, instr_pc=1.
- **Stall:** stall=1 for 3 cycles while instr_pc=4.
  - instr stays 32'h1000_0004, rom_ena=0, fetch_count unchanged.
  - After release: instr_pc 4 held one cycle, then 5, 6.
- **Branch:** branch_taken=1 with branch_target=25 at instr_pc=3.
  - Next cycle: instr=32'h1000_0019, instr_pc=25; then 26.
  - Repeat with stall=1 asserted at the same time: same result.
- **Wrap-around:** branch to 1022.
  - instr_pc sequence 1022, 1023, 0, 1; instr 32'h1000_03FE, 32'h1000_03FF, 32'h1000_0000.
- **Halt:** mem[5]=HALT_WORD.
  - instr_pc=5 is delivered with instr_valid=1.
  - Next cycle: halted=1, instr_valid=0, rom_ena=0, fetch_count=6; stays halted under branch_taken.
  - Reset restarts at pc 0.
- **Reset mid-run:** reset at instr_pc=7.
  - Next cycle: instr_valid=0, fetch_count=0, rom_addra=0.
  - Normal restart follows.
